// File: rtl/mips32_if.sv
// Status bundle exported by the mips32 core: halt flag and current fetch PC.
interface mips32_if;
  logic        halted;
  logic [31:0] pc;

  modport master (output halted, output pc);
  modport slave  (input halted, input pc);
endinterface

// File: rtl/mips32.sv
// Five-stage in-order MIPS-like core with internal register file and unified
// word-addressed instruction/data memory; control flow resolves in EX.
module mips32 #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic     clk1,
  input  logic     rst,
  mips32_if.master dbg
);

  localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned XW = 32;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_JAL   = 6'b010000;
  localparam logic [5:0] OP_JR    = 6'b010001;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  typedef enum logic [3:0] {
    K_NOP, K_RR, K_RI, K_LW, K_SW, K_BNEQZ, K_BEQZ, K_JAL, K_JR, K_HLT
  } kind_e;

  // Architectural / hierarchically visible state
  logic [XW-1:0] Reg [0:31];
  logic [XW-1:0] Mem [0:MEM_WORDS-1];
  logic [XW-1:0] PC;
  logic          HALTED;
  logic          TAKEN_BRANCH;
  logic          fetch_stop;

  // IF/ID
  logic          ifid_v;
  logic [XW-1:0] ifid_ir;
  logic [XW-1:0] ifid_npc;

  // ID/EX
  logic          idex_v;
  kind_e         idex_k;
  logic [5:0]    idex_op;
  logic [4:0]    idex_rs, idex_rt, idex_dst;
  logic [XW-1:0] idex_a, idex_b, idex_imm, idex_tgt, idex_npc;

  // EX/MEM
  logic          exmem_v;
  kind_e         exmem_k;
  logic [4:0]    exmem_dst;
  logic [XW-1:0] exmem_alu, exmem_b;

  // MEM/WB
  logic          memwb_v;
  logic          memwb_hlt;
  logic [4:0]    memwb_dst;
  logic [XW-1:0] memwb_val;

  function automatic logic [AW-1:0] widx(input logic [XW-1:0] a);
    return AW'(a % MEM_WORDS);
  endfunction

  // ID: decode fields, register read with WB bypass, load-use detection
  logic [5:0]    id_op;
  logic [4:0]    id_rs, id_rt, id_rd, id_dst;
  logic [XW-1:0] id_a, id_b, id_imm, id_tgt;
  kind_e         id_k;
  logic          load_use_c;

  always_comb begin
    id_op  = ifid_ir[31:26];
    id_rs  = ifid_ir[25:21];
    id_rt  = ifid_ir[20:16];
    id_rd  = ifid_ir[15:11];
    id_imm = {{16{ifid_ir[15]}}, ifid_ir[15:0]};
    id_tgt = {6'd0, ifid_ir[25:0]};
    id_k   = K_NOP;
    id_dst = 5'd0;
    case (id_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
        id_k = K_RR; id_dst = id_rd;
      end
      OP_ADDI, OP_SUBI, OP_SLTI: begin id_k = K_RI; id_dst = id_rt; end
      OP_LW:    begin id_k = K_LW; id_dst = id_rt; end
      OP_SW:    id_k = K_SW;
      OP_BNEQZ: id_k = K_BNEQZ;
      OP_BEQZ:  id_k = K_BEQZ;
      OP_JAL:   begin id_k = K_JAL; id_dst = 5'd31; end
      OP_JR:    id_k = K_JR;
      OP_HLT:   id_k = K_HLT;
      default:  id_k = K_NOP;
    endcase
    id_a = (memwb_v && memwb_dst != 5'd0 && memwb_dst == id_rs) ? memwb_val : Reg[id_rs];
    id_b = (memwb_v && memwb_dst != 5'd0 && memwb_dst == id_rt) ? memwb_val : Reg[id_rt];
    load_use_c = idex_v && idex_k == K_LW && idex_dst != 5'd0 && ifid_v &&
                 (idex_dst == id_rs || idex_dst == id_rt);
  end

  // EX: operand forwarding, ALU and control-flow resolution
  logic [XW-1:0] fa, fb, alu_c, tgt_c;
  logic          take_c, hlt_ex_c;

  always_comb begin
    fa = idex_a;
    if (exmem_v && exmem_dst != 5'd0 && exmem_dst == idex_rs) fa = exmem_alu;
    else if (memwb_v && memwb_dst != 5'd0 && memwb_dst == idex_rs) fa = memwb_val;
    fb = idex_b;
    if (exmem_v && exmem_dst != 5'd0 && exmem_dst == idex_rt) fb = exmem_alu;
    else if (memwb_v && memwb_dst != 5'd0 && memwb_dst == idex_rt) fb = memwb_val;

    alu_c = '0;
    case (idex_k)
      K_RR: begin
        case (idex_op)
          OP_ADD:  alu_c = fa + fb;
          OP_SUB:  alu_c = fa - fb;
          OP_AND:  alu_c = fa & fb;
          OP_OR:   alu_c = fa | fb;
          OP_SLT:  alu_c = {31'd0, $signed(fa) < $signed(fb)};
          OP_MUL:  alu_c = fa * fb;
          default: alu_c = '0;
        endcase
      end
      K_RI: begin
        case (idex_op)
          OP_ADDI: alu_c = fa + idex_imm;
          OP_SUBI: alu_c = fa - idex_imm;
          OP_SLTI: alu_c = {31'd0, $signed(fa) < $signed(idex_imm)};
          default: alu_c = '0;
        endcase
      end
      K_LW, K_SW: alu_c = fa + idex_imm;
      K_JAL:      alu_c = idex_npc;
      default:    alu_c = '0;
    endcase

    take_c = idex_v && ((idex_k == K_BNEQZ && fa != '0) ||
                        (idex_k == K_BEQZ && fa == '0) ||
                        idex_k == K_JAL || idex_k == K_JR);
    tgt_c = idex_npc + idex_imm;
    if (idex_k == K_JAL) tgt_c = idex_tgt;
    else if (idex_k == K_JR) tgt_c = fa;
    hlt_ex_c = idex_v && idex_k == K_HLT;
  end

  assign dbg.pc = PC;

  // Pipeline advance; Reg[] and Mem[] are deliberately left out of reset
  always_ff @(posedge clk1) begin
    if (rst) begin
      PC           <= '0;
      HALTED       <= 1'b0;
      TAKEN_BRANCH <= 1'b0;
      fetch_stop   <= 1'b0;
      ifid_v       <= 1'b0;
      idex_v       <= 1'b0;
      exmem_v      <= 1'b0;
      memwb_v      <= 1'b0;
      dbg.halted   <= 1'b0;
    end else begin
      TAKEN_BRANCH <= take_c;
      fetch_stop   <= fetch_stop | hlt_ex_c;
      dbg.halted   <= HALTED;

      // IF: a taken transfer overrides any load-use hold
      if (take_c) begin
        PC     <= tgt_c;
        ifid_v <= 1'b0;
      end else if (hlt_ex_c || fetch_stop || HALTED) begin
        ifid_v <= 1'b0;
      end else if (!load_use_c) begin
        PC       <= PC + 32'd1;
        ifid_v   <= 1'b1;
        ifid_ir  <= Mem[widx(PC)];
        ifid_npc <= PC + 32'd1;
      end

      // ID -> EX
      idex_v   <= ifid_v && !take_c && !hlt_ex_c && !load_use_c;
      idex_k   <= id_k;
      idex_op  <= id_op;
      idex_rs  <= id_rs;
      idex_rt  <= id_rt;
      idex_dst <= id_dst;
      idex_a   <= id_a;
      idex_b   <= id_b;
      idex_imm <= id_imm;
      idex_tgt <= id_tgt;
      idex_npc <= ifid_npc;

      // EX -> MEM
      exmem_v   <= idex_v;
      exmem_k   <= idex_k;
      exmem_dst <= idex_dst;
      exmem_alu <= alu_c;
      exmem_b   <= fb;

      // MEM -> WB
      memwb_v   <= exmem_v;
      memwb_dst <= exmem_dst;
      memwb_hlt <= exmem_k == K_HLT;
      memwb_val <= (exmem_k == K_LW) ? Mem[widx(exmem_alu)] : exmem_alu;
      if (exmem_v && exmem_k == K_SW && !HALTED) Mem[widx(exmem_alu)] <= exmem_b;

      // WB
      if (memwb_v && !HALTED) begin
        if (memwb_dst != 5'd0) Reg[memwb_dst] <= memwb_val;
        if (memwb_hlt) HALTED <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mips32.sv
// Directed program runs for mips32; expected architectural state is queued
// when each program is loaded and compared once the core halts.
module tb_mips32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips32_if dbg ();
  mips32 #(.MEM_WORDS(1024)) dut (.clk1(clk), .rst(rst), .dbg(dbg));

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ORR = 6'b000011,
                         MUL = 6'b000101, LW = 6'b001000, SW = 6'b001001,
                         ADDI = 6'b001010, SUBI = 6'b001011, BNEQZ = 6'b001101,
                         BEQZ = 6'b001110, JAL = 6'b010000, HLT = 6'b111111;

  typedef struct {
    string       tag;
    int          kind;   // 0 reg, 1 mem, 2 pc
    int          idx;
    logic [31:0] exp;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] prog[$];
  int          npass  = 0;
  int          ntotal = 0;

  function automatic logic [31:0] enc_r(input logic [5:0] op, input int rd, input int rs, input int rt);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input int tgt);
    return {op, 26'(tgt)};
  endfunction

  function automatic logic [31:0] observe(input sb_t e);
    case (e.kind)
      0:       return dut.Reg[e.idx];
      1:       return dut.Mem[e.idx];
      default: return dbg.pc;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic expect_st(input string tag, input int kind, input int idx, input logic [31:0] exp);
    sb.push_back('{tag: tag, kind: kind, idx: idx, exp: exp});
  endtask

  // Hold reset, preload Reg[i]=i and the program image (rest of low memory zeroed)
  task automatic load_prog();
    rst = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 32; i++) dut.Reg[i] <= 32'(i);
    for (int i = 0; i < 256; i++) dut.Mem[i] <= (i < prog.size()) ? prog[i] : 32'd0;
  endtask

  task automatic release_rst(input string name);
    @(posedge clk);
    @(negedge clk);
    check({name, "_rst_pc"}, dbg.pc, 32'd0);
    check({name, "_rst_halted"}, 32'(dbg.halted), 32'd0);
    rst = 1'b0;
  endtask

  task automatic wait_and_drain(input string name, input int budget);
    int n;
    sb_t e;
    n = 0;
    while (dbg.halted !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_halted"}, 32'(dbg.halted), 32'd1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e), e.exp);
    end
  endtask

  task automatic factorial_prog();
    prog = '{};
    prog.push_back(enc_i(ADDI, 10, 0, 200));
    prog.push_back(enc_i(ADDI, 2, 0, 1));
    prog.push_back(enc_r(ORR, 0, 0, 0));
    prog.push_back(enc_i(LW, 3, 10, 0));
    prog.push_back(enc_r(ORR, 0, 0, 0));
    prog.push_back(enc_r(MUL, 2, 2, 3));
    prog.push_back(enc_i(SUBI, 3, 3, 1));
    prog.push_back(enc_r(ORR, 0, 0, 0));
    prog.push_back(enc_i(BNEQZ, 0, 3, -4));
    prog.push_back(enc_i(SW, 2, 10, -2));
    prog.push_back(enc_j(HLT, 0));
  endtask

  task automatic factorial_expect(input string name);
    expect_st({name, "_mem198"}, 1, 198, 32'd5040);
    expect_st({name, "_r2"}, 0, 2, 32'd5040);
    expect_st({name, "_r3"}, 0, 3, 32'd0);
    expect_st({name, "_r10"}, 0, 10, 32'd200);
    expect_st({name, "_pc_frozen"}, 2, 0, 32'd12);
  endtask

  initial begin
    // Factorial of 7 with a loop-closing branch
    factorial_prog();
    load_prog();
    dut.Mem[200] <= 32'd7;
    factorial_expect("fact");
    release_rst("fact");
    wait_and_drain("fact", 2000);

    // Store/load forwarding and load-use stall without fillers
    prog = '{};
    prog.push_back(enc_i(ADDI, 1, 0, 200));
    prog.push_back(enc_i(ADDI, 2, 0, 50));
    prog.push_back(enc_i(SW, 2, 1, 0));
    prog.push_back(enc_i(LW, 3, 1, 0));
    prog.push_back(enc_r(ADD, 4, 3, 3));
    prog.push_back(enc_r(SUB, 5, 4, 3));
    prog.push_back(enc_j(HLT, 0));
    load_prog();
    expect_st("haz_mem200", 1, 200, 32'd50);
    expect_st("haz_r3", 0, 3, 32'd50);
    expect_st("haz_r4", 0, 4, 32'd100);
    expect_st("haz_r5", 0, 5, 32'd50);
    expect_st("haz_pc_frozen", 2, 0, 32'd8);
    release_rst("haz");
    wait_and_drain("haz", 500);

    // JAL/JR with squash of the instruction after JAL
    prog = '{};
    prog.push_back(enc_i(ADDI, 1, 0, 9));
    prog.push_back(enc_j(JAL, 8));
    prog.push_back(enc_i(ADDI, 2, 0, 100));
    for (int i = 3; i < 8; i++) prog.push_back(enc_r(ORR, 0, 0, 0));
    prog.push_back(32'h4420_0000);
    prog.push_back(enc_i(ADDI, 6, 0, 77));
    prog.push_back(enc_j(HLT, 0));
    load_prog();
    expect_st("jmp_r31", 0, 31, 32'd2);
    expect_st("jmp_r2", 0, 2, 32'd2);
    expect_st("jmp_r6", 0, 6, 32'd77);
    expect_st("jmp_r1", 0, 1, 32'd9);
    expect_st("jmp_pc_frozen", 2, 0, 32'd12);
    release_rst("jmp");
    wait_and_drain("jmp", 500);

    // BEQZ taken: two younger instructions squashed; nothing after HLT writes
    prog = '{};
    prog.push_back(enc_i(ADDI, 5, 0, 0));
    prog.push_back(enc_i(BEQZ, 0, 5, 3));
    prog.push_back(enc_i(ADDI, 7, 0, 111));
    prog.push_back(enc_i(ADDI, 8, 0, 222));
    prog.push_back(enc_i(ADDI, 9, 0, 333));
    prog.push_back(enc_i(ADDI, 11, 0, 55));
    prog.push_back(enc_j(HLT, 0));
    prog.push_back(enc_i(ADDI, 12, 0, 66));
    load_prog();
    expect_st("beqz_r7", 0, 7, 32'd7);
    expect_st("beqz_r8", 0, 8, 32'd8);
    expect_st("beqz_r9", 0, 9, 32'd9);
    expect_st("beqz_r11", 0, 11, 32'd55);
    expect_st("beqz_r12_after_hlt", 0, 12, 32'd12);
    expect_st("beqz_pc_frozen", 2, 0, 32'd8);
    release_rst("beqz");
    wait_and_drain("beqz", 500);

    // Writes to R0 are discarded and never forwarded
    prog = '{};
    prog.push_back(enc_i(ADDI, 0, 0, 5));
    prog.push_back(enc_r(ADD, 13, 0, 0));
    prog.push_back(enc_j(HLT, 0));
    prog.push_back(enc_i(ADDI, 14, 0, 99));
    load_prog();
    expect_st("r0_r0", 0, 0, 32'd0);
    expect_st("r0_r13", 0, 13, 32'd0);
    expect_st("r0_r14_after_hlt", 0, 14, 32'd14);
    expect_st("r0_pc_frozen", 2, 0, 32'd4);
    release_rst("r0");
    wait_and_drain("r0", 500);

    // Reset pulse mid-run restarts at PC 0 and reruns to the same results
    factorial_prog();
    load_prog();
    dut.Mem[200] <= 32'd7;
    release_rst("mid");
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_pc_after_rst", dbg.pc, 32'd0);
    check("mid_HALTED_after_rst", 32'(dut.HALTED), 32'd0);
    check("mid_halted_after_rst", 32'(dbg.halted), 32'd0);
    check("mid_mem198_untouched", dut.Mem[198], 32'd0);
    rst = 1'b0;
    factorial_expect("mid");
    wait_and_drain("mid", 2000);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
